// File: rtl/protobuf_write_arbiter.sv
// rtl/protobuf_write_arbiter.sv - round-robin arbiter sharing one AXI4 write port between N field producers
// Each accepted beat becomes one single-beat AXI write; ownership is held from first beat to last.
module protobuf_write_arbiter #(
  parameter int         N       = 2,
  parameter logic [3:0] ID_BASE = 4'h0
) (
  input  logic            clock_clk,
  input  logic            reset_reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_data,
  input  logic [4*N-1:0]  req_strb,
  input  logic [7*N-1:0]  req_enc,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            id_err,
  output logic [3:0]      axm_awid,
  output logic [15:0]     axm_awaddr,
  output logic [7:0]      axm_awlen,
  output logic [2:0]      axm_awsize,
  output logic [1:0]      axm_awburst,
  output logic            axm_awvalid,
  input  logic            axm_awready,
  output logic [31:0]     axm_wdata,
  output logic [3:0]      axm_wstrb,
  output logic            axm_wvalid,
  input  logic            axm_wready,
  input  logic [3:0]      axm_bid,
  input  logic            axm_bvalid,
  output logic            axm_bready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, HOLD} state_t;

  state_t        state, state_n;
  logic [IW-1:0] rr_ptr, owner, win, sel, cand;
  logic [N-1:0]  sel_oh;
  logic          found, accept, last_q, aw_pend, w_pend;

  logic [31:0] data_a [N];
  logic [3:0]  strb_a [N];
  logic [6:0]  enc_a  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_a[i] = req_data[32*i +: 32];
    assign strb_a[i] = req_strb[4*i +: 4];
    assign enc_a[i]  = req_enc[7*i +: 7];
  end

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    sel       = owner;
    req_ready = '0;
    sel_oh    = '0;
    case (state)
      IDLE:  if (found) begin
               sel     = win;
               accept  = 1'b1;
               state_n = ISSUE;
             end
      ISSUE: if ((!aw_pend || axm_awready) && (!w_pend || axm_wready)) state_n = RESP;
      RESP:  if (axm_bvalid) state_n = last_q ? IDLE : HOLD;
      HOLD:  if (req_valid[owner]) begin
               accept  = 1'b1;
               state_n = ISSUE;
             end
      default: state_n = IDLE;
    endcase
    sel_oh[sel] = 1'b1;
    if (accept) req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      rr_ptr     <= '0;
      owner      <= '0;
      last_q     <= 1'b0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      grant      <= '0;
      id_err     <= 1'b0;
      axm_awaddr <= '0;
      axm_wdata  <= '0;
      axm_wstrb  <= '0;
      axm_awid   <= '0;
    end else begin
      if (accept) begin
        owner      <= sel;
        last_q     <= req_last[sel];
        axm_awaddr <= {8'h00, enc_a[sel], req_last[sel]};
        axm_wdata  <= data_a[sel];
        axm_wstrb  <= strb_a[sel];
        axm_awid   <= ID_BASE + 4'(sel);
        aw_pend    <= 1'b1;
        w_pend     <= 1'b1;
        grant      <= sel_oh;
      end
      // AW and W retire independently; either may lead.
      if (state == ISSUE) begin
        if (axm_awready) aw_pend <= 1'b0;
        if (axm_wready)  w_pend  <= 1'b0;
      end
      if (state == RESP && axm_bvalid) begin
        if (axm_bid != axm_awid) id_err <= 1'b1;
        if (last_q) begin
          grant  <= '0;
          rr_ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
        end
      end
    end
  end

  assign axm_awlen   = 8'h00;
  assign axm_awsize  = 3'b010;
  assign axm_awburst = 2'b00;
  assign axm_awvalid = aw_pend;
  assign axm_wvalid  = w_pend;
  assign axm_bready  = (state == RESP);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_protobuf_write_arbiter.sv
// tb/tb_protobuf_write_arbiter.sv - directed bench for protobuf_write_arbiter with a delay-configurable AXI slave
module tb_protobuf_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_last, grant;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [13:0] req_enc;
  logic        busy, id_err;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb, bid;

  protobuf_write_arbiter #(.N(2), .ID_BASE(4'h0)) dut (
    .clock_clk(clk), .reset_reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_strb(req_strb), .req_enc(req_enc), .req_last(req_last),
    .grant(grant), .busy(busy), .id_err(id_err),
    .axm_awid(awid), .axm_awaddr(awaddr), .axm_awlen(awlen), .axm_awsize(awsize),
    .axm_awburst(awburst), .axm_awvalid(awvalid), .axm_awready(awready),
    .axm_wdata(wdata), .axm_wstrb(wstrb), .axm_wvalid(wvalid), .axm_wready(wready),
    .axm_bid(bid), .axm_bvalid(bvalid), .axm_bready(bready)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic [6:0] e; logic l;} beat_t;

  int errors = 0, checks = 0;
  beat_t q0[$], q1[$];
  int acc[$], accb[$];
  bit acc_last = 1'b0;

  int aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [3:0] bid_xor = 4'h0;
  logic [15:0] aw_addr_log[$];
  logic [3:0]  aw_id_log[$];
  logic [31:0] w_data_log[$];
  logic [3:0]  w_strb_log[$];
  int b_cnt = 0, stab_err = 0, aw_only = 0, w_only = 0, bready_err = 0;

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] s, input logic [6:0] e, input logic l);
    return {d, s, e, l};
  endfunction

  // AXI slave: decides ready/valid at each falling edge for the following rising edge.
  initial begin
    int aw_wait = 0, w_wait = 0, b_wait = 0;
    bit b_pend = 0, b_taken = 0, aw_got = 0, w_got = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [15:0] p_addr = 0;
    logic [3:0]  p_id = 0, p_ws = 0;
    logic [31:0] p_wd = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_wait = 0; w_wait = 0; b_wait = 0;
        b_pend = 0; b_taken = 0; aw_got = 0; w_got = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        awready = 0; wready = 0; bvalid = 0;
      end else begin
        if (p_awv && !p_awr && (!awvalid || awaddr !== p_addr || awid !== p_id)) stab_err++;
        if (p_wv && !p_wr && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) stab_err++;
        if (awvalid && !wvalid) aw_only++;
        if (wvalid && !awvalid) w_only++;
        if (b_pend && !bready) bready_err++;
        if (b_taken) begin
          bvalid = 0; b_taken = 0;
        end else if (b_pend) begin
          if (b_wait >= b_delay) begin
            bvalid = 1; bid = aw_id_log[$] ^ bid_xor; b_pend = 0;
          end else b_wait++;
        end
        if (bvalid && bready) begin b_taken = 1; b_cnt++; end
        awready = 0;
        if (awvalid) begin
          if (aw_wait >= aw_delay) begin
            awready = 1; aw_wait = 0; aw_got = 1;
            aw_addr_log.push_back(awaddr); aw_id_log.push_back(awid);
          end else aw_wait++;
        end
        wready = 0;
        if (wvalid) begin
          if (w_wait >= w_delay) begin
            wready = 1; w_wait = 0; w_got = 1;
            w_data_log.push_back(wdata); w_strb_log.push_back(wstrb);
          end else w_wait++;
        end
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
        p_awv = awvalid; p_awr = awready; p_addr = awaddr; p_id = awid;
        p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
      end
    end
  end

  // Called just after a falling edge: present queue heads, record accepted beats.
  task automatic step();
    beat_t h0, h1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    req_valid = {q1.size() > 0, q0.size() > 0};
    req_data  = {h1.d, h0.d};
    req_strb  = {h1.s, h0.s};
    req_enc   = {h1.e, h0.e};
    req_last  = {h1.l, h0.l};
    #1;
    acc_last = 1'b0;
    if (req_valid[0] && req_ready[0]) begin acc.push_back(0); accb.push_back(b_cnt); void'(q0.pop_front()); acc_last = 1'b1; end
    if (req_valid[1] && req_ready[1]) begin acc.push_back(1); accb.push_back(b_cnt); void'(q1.pop_front()); acc_last = 1'b1; end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !busy && !acc_last) done = 1;
      else begin step(); n++; end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL run_timeout got=not_idle required=idle within %0d cycles", budget); end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1; req_valid = '0;
    @(negedge clk); @(negedge clk); #2 rst = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({awvalid, wvalid, bready, grant, busy, id_err, req_ready} !== 9'h0) begin
      errors++; $display("FAIL reset_ctrl got=%b required=0", {awvalid, wvalid, bready, grant, busy, id_err, req_ready});
    end
    checks++;
    if ({awaddr, wdata, wstrb, awid} !== 56'h0) begin
      errors++; $display("FAIL reset_data got=%h required=0", {awaddr, wdata, wstrb, awid});
    end
    checks++;
    if ({awlen, awsize, awburst} !== {8'h00, 3'b010, 2'b00}) begin
      errors++; $display("FAIL fixed_fields got=%h required=%h", {awlen, awsize, awburst}, {8'h00, 3'b010, 2'b00});
    end
    #1 rst = 0;
  endtask

  task automatic test_single_field();
    int a0 = aw_addr_log.size(), c0 = acc.size();
    logic [15:0] ea [2] = '{16'hF0, 16'hF1};
    logic [31:0] ed [2] = '{32'h6972616D, 32'h006E6F6D};
    logic [3:0]  es [2] = '{4'hF, 4'h7};
    q0.push_back(mk(32'h6972616D, 4'hF, 7'h78, 1'b0));
    q0.push_back(mk(32'h006E6F6D, 4'h7, 7'h78, 1'b1));
    run_until_idle(100);
    checks++;
    if (aw_addr_log.size() - a0 !== 2 || w_data_log.size() - a0 !== 2) begin
      errors++; $display("FAIL single_count got=%0d/%0d required=2", aw_addr_log.size() - a0, w_data_log.size() - a0);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({aw_addr_log[a0+i], w_data_log[a0+i], w_strb_log[a0+i], aw_id_log[a0+i]} !== {ea[i], ed[i], es[i], 4'h0}) begin
        errors++; $display("FAIL single_write%0d got=%h required=%h", i,
          {aw_addr_log[a0+i], w_data_log[a0+i], w_strb_log[a0+i], aw_id_log[a0+i]}, {ea[i], ed[i], es[i], 4'h0});
      end
    end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_idle got=%b required=00", grant); end
    q0.push_back(mk(32'h11111111, 4'hF, 7'h78, 1'b1));
    q1.push_back(mk(32'h22222222, 4'hF, 7'h78, 1'b1));
    run_until_idle(100);
    checks++;
    if (acc[c0+2] !== 1 || acc[c0+3] !== 0) begin
      errors++; $display("FAIL rr_ptr_after_field got=%0d,%0d required=1,0", acc[c0+2], acc[c0+3]);
    end
  endtask

  task automatic test_contention();
    int a0 = w_data_log.size(), c0 = acc.size(), b0 = b_cnt;
    logic [31:0] ed [4] = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hB1B1_0000, 32'hB1B1_0001};
    logic [15:0] ea [4] = '{16'hF0, 16'hF1, 16'hF0, 16'hF1};
    logic [3:0]  ei [4] = '{4'h0, 4'h0, 4'h1, 4'h1};
    q0.push_back(mk(ed[0], 4'hF, 7'h78, 1'b0)); q0.push_back(mk(ed[1], 4'hF, 7'h78, 1'b1));
    q1.push_back(mk(ed[2], 4'hF, 7'h78, 1'b0)); q1.push_back(mk(ed[3], 4'hF, 7'h78, 1'b1));
    run_until_idle(200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({w_data_log[a0+i], aw_addr_log[a0+i], aw_id_log[a0+i]} !== {ed[i], ea[i], ei[i]}) begin
        errors++; $display("FAIL contention_write%0d got=%h required=%h", i,
          {w_data_log[a0+i], aw_addr_log[a0+i], aw_id_log[a0+i]}, {ed[i], ea[i], ei[i]});
      end
    end
    checks++;
    if (acc[c0+2] !== 1 || accb[c0+2] - b0 !== 2) begin
      errors++; $display("FAIL contention_r1_wait got=req%0d after %0d B required=req1 after 2 B", acc[c0+2], accb[c0+2] - b0);
    end
  endtask

  task automatic test_fairness();
    int a0 = aw_id_log.size(), c0 = acc.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'h0F00_0000 + i, 4'hF, 7'h78, 1'b1));
      q1.push_back(mk(32'h0F10_0000 + i, 4'hF, 7'h78, 1'b1));
    end
    run_until_idle(300);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc[c0+i] !== i % 2 || aw_id_log[a0+i] !== 4'(i % 2)) begin
        errors++; $display("FAIL fairness_field%0d got=req%0d id%0h required=req%0d", i, acc[c0+i], aw_id_log[a0+i], i % 2);
      end
    end
  endtask

  task automatic test_aw_w_independent();
    int a0 = aw_addr_log.size(), b0 = b_cnt, s0 = stab_err;
    int ao = aw_only, wo = w_only;
    aw_delay = 3;
    q0.push_back(mk(32'hDEAD_0001, 4'h3, 7'h78, 1'b1));
    run_until_idle(100);
    aw_delay = 0;
    checks++;
    if (aw_only - ao !== 3 || w_only - wo !== 0) begin
      errors++; $display("FAIL aw_late got=aw_only %0d w_only %0d required=3 0", aw_only - ao, w_only - wo);
    end
    ao = aw_only; wo = w_only;
    w_delay = 3;
    q1.push_back(mk(32'hDEAD_0002, 4'hC, 7'h78, 1'b1));
    run_until_idle(100);
    w_delay = 0;
    checks++;
    if (w_only - wo !== 3 || aw_only - ao !== 0) begin
      errors++; $display("FAIL w_late got=w_only %0d aw_only %0d required=3 0", w_only - wo, aw_only - ao);
    end
    checks++;
    if (aw_addr_log.size() - a0 !== 2 || w_data_log.size() - a0 !== 2 || b_cnt - b0 !== 2 || stab_err - s0 !== 0) begin
      errors++; $display("FAIL aw_w_one_write got=aw%0d w%0d b%0d unstable%0d required=2 2 2 0",
        aw_addr_log.size() - a0, w_data_log.size() - a0, b_cnt - b0, stab_err - s0);
    end
  endtask

  task automatic test_b_backpressure();
    int be0 = bready_err;
    checks++;
    if (id_err !== 1'b0) begin errors++; $display("FAIL id_err_clean got=%b required=0", id_err); end
    b_delay = 5; bid_xor = 4'h5;
    q0.push_back(mk(32'h0B0B_0B0B, 4'hF, 7'h78, 1'b1));
    run_until_idle(100);
    b_delay = 0; bid_xor = 4'h0;
    checks++;
    if (id_err !== 1'b1 || bready_err - be0 !== 0) begin
      errors++; $display("FAIL bid_mismatch got=id_err %b bready_drops %0d required=1 0", id_err, bready_err - be0);
    end
    q0.push_back(mk(32'h0C0C_0C0C, 4'hF, 7'h78, 1'b1));
    run_until_idle(100);
    checks++;
    if (id_err !== 1'b1) begin errors++; $display("FAIL id_err_sticky got=%b required=1", id_err); end
  endtask

  task automatic test_mid_reset();
    int a0, c0;
    aw_delay = 10; w_delay = 10;
    q0.push_back(mk(32'h5555_0000, 4'hF, 7'h78, 1'b0));
    q0.push_back(mk(32'h5555_0001, 4'hF, 7'h78, 1'b1));
    @(negedge clk); step();
    @(negedge clk); step();
    checks++;
    if ({awvalid, wvalid, grant} !== 4'b1101) begin
      errors++; $display("FAIL pre_reset_issue got=%b required=1101", {awvalid, wvalid, grant});
    end
    @(negedge clk); #2;
    rst = 1; req_valid = '0; q0.delete(); q1.delete(); aw_delay = 0; w_delay = 0;
    @(negedge clk); #1;
    checks++;
    if ({awvalid, wvalid, bready, grant, busy, id_err} !== 7'h0) begin
      errors++; $display("FAIL mid_reset got=%b required=0", {awvalid, wvalid, bready, grant, busy, id_err});
    end
    #1 rst = 0;
    a0 = aw_addr_log.size(); c0 = acc.size();
    q1.push_back(mk(32'hC0DE_C0DE, 4'h0, 7'h78, 1'b1));
    run_until_idle(100);
    checks++;
    if (acc[c0] !== 1 || {aw_addr_log[a0], aw_id_log[a0], w_data_log[a0], w_strb_log[a0]} !== {16'hF1, 4'h1, 32'hC0DE_C0DE, 4'h0}) begin
      errors++; $display("FAIL post_reset_req1 got=req%0d %h required=req1 %h", acc[c0],
        {aw_addr_log[a0], aw_id_log[a0], w_data_log[a0], w_strb_log[a0]}, {16'hF1, 4'h1, 32'hC0DE_C0DE, 4'h0});
    end
  endtask

  initial begin
    rst = 1; req_valid = '0; req_data = '0; req_strb = '0; req_enc = '0; req_last = '0;
    test_reset();
    test_single_field();
    do_reset();
    test_contention();
    test_fairness();
    test_aw_w_independent();
    test_b_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/protobuf_write_arbiter.md
Name: protobuf_write_arbiter

Overview:
- Shares the single AXI4 write port of protobuf_serializer between N requesters using round-robin arbitration.
- Each requester pushes field fragments as 32-bit beats over a valid/ready interface. The arbiter converts each beat into one single-beat AXI write (AW+W+B).
- A field is a run of beats ending with last. Ownership is held until last, so fields from different requesters never interleave in the serializer.
- Sits between the host-side field producers and the serializer slave (axs_s0_*).

Parameters:
- N, 2, number of requesters (2..8).
- ID_BASE, 4'h0, awid issued for requester i is ID_BASE+i (4-bit wrap).

Ports:
- clock_clk  in  1  clock.
- reset_reset  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i has a beat.
- req_ready  out  N  one-hot; beat of requester i accepted this cycle.
- req_data  in  32*N  beat data, slice i = [32i+31:32i].
- req_strb  in  4*N  byte strobes, slice i.
- req_enc  in  7*N  encoding code (raw data = 7'h78), slice i.
- req_last  in  N  beat is the final beat of the field.
- grant  out  N  one-hot current owner; 0 when idle.
- busy  out  1  state != IDLE.
- id_err  out  1  sticky; set when a B response carries bid != expected id.
- axm_awid/awaddr/awlen/awsize/awburst/awvalid  out  4/16/8/3/2/1  AXI write address.
- axm_awready  in  1.
- axm_wdata/wstrb/wvalid  out  32/4/1  AXI write data.
- axm_wready  in  1.
- axm_bid  in  4.
- axm_bvalid  in  1.
- axm_bready  out  1.

Behaviour:
- Reset (synchronous): state=IDLE, rr_ptr=0, grant=0, busy=0, id_err=0.
- Reset values of the AXI outputs: awvalid=0, wvalid=0, bready=0, awaddr=0, wdata=0, wstrb=0, awid=0.
- Reset mid-transaction abandons the in-flight write with no completion. The serializer shares the same reset.
- Fixed AXI fields: awlen=8'h00, awsize=3'b010, awburst=2'b00.
- awaddr = {8'h00, enc[6:0], last}. Raw data gives 16'hF0 for non-last and 16'hF1 for last.
- States: IDLE, ISSUE, RESP, HOLD.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 for that cycle (combinational). The beat, enc, last and winner are registered.
  - Next state ISSUE. grant=onehot(winner) from the next cycle.
- ISSUE:
  - awvalid and wvalid are both asserted on entry.
  - Each deasserts independently on its own handshake (awvalid&awready, wvalid&wready). Either may complete first, or both in the same cycle.
  - Once both have handshaken, go to RESP.
  - Outputs are held stable while valid is high.
- RESP:
  - bready=1. On bvalid, compare bid with ID_BASE+owner; set id_err on mismatch.
  - If last: rr_ptr=owner+1 (mod N), grant=0, go to IDLE.
  - If not last: go to HOLD.
- HOLD:
  - Only the owner is eligible; other requesters' req_valid is ignored. The owner is held indefinitely and there is no timeout.
  - On req_valid[owner]: req_ready[owner]=1, the beat is captured, go to ISSUE.
- No new beat is accepted while a write is outstanding; at most one AXI write is in flight.
- Zero-strobe beats are passed through unchanged.
- Minimum per beat is 3 cycles: accept, then ISSUE (one cycle when awready and wready are both high), then RESP (one cycle when bvalid arrives immediately).
- Simultaneous requests in IDLE are resolved purely by rr_ptr. A requester asserting req_valid during another's field waits until that field's last response.

Test Plan:
- Single field, N=2: req0 sends 0x6972616D (strb F, not last), then 0x006E6F6D (strb 7, last, enc 78). Required: two AXI writes with awaddr F0 then F1, wdata/wstrb matching, awid 0, grant returns to 0, rr_ptr=1.
- Contention: req0 and req1 both valid in IDLE with rr_ptr=0, each sending a 2-beat field. Required AXI order: r0b0, r0b1, r1b0, r1b1. req1 sees no req_ready until r0's last B response.
- Fairness: both requesters continuously send 1-beat fields. Required: grants alternate 0,1,0,1 over 8 fields.
- Independent AW/W: awready delayed 3 cycles while wready is immediate, then the reverse. Required: each valid drops only on its own handshake, and exactly one write completes per beat.
- B back-pressure and bid check: bvalid delayed 5 cycles, then bid=4'h5 returned for requester 0. Required: bready held high throughout, id_err=1 and sticky until reset.
- Mid-field reset: reset asserted during ISSUE of a non-last beat. Required: next cycle all valids are 0, grant=0, id_err=0, and a fresh req1 field is granted first.
